// File: rtl/dma_pkg.sv
// Shared constants and FSM state encoding for the DMA transfer controller slice.
package dma_pkg;

  localparam int unsigned MEM_AW    = 9;
  localparam int unsigned MEM_DEPTH = 512;
  localparam int unsigned BLOCK_W   = 10;
  localparam int unsigned BURST_W   = 8;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BUS_AW    = 32;

  // Byte stride of one 32-bit word on the system bus
  localparam logic [BUS_AW-1:0] BUS_WORD_STEP = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQUEST   = 3'd1,
    ST_BEGIN     = 3'd2,
    ST_READ      = 3'd3,
    ST_WRITE     = 3'd4,
    ST_END_WRITE = 3'd5,
    ST_FINISH    = 3'd6,
    ST_ERROR     = 3'd7
  } dma_state_e;

endpackage

// File: rtl/dma_transfer_controller_if.sv
// System bus signals between the DMA controller (master) and the bus/arbiter (slave).
interface dma_transfer_controller_if #(
  parameter int unsigned BURST_W = dma_pkg::BURST_W
);

  logic                requestTransaction;
  logic                transactionGranted;
  logic                beginTransactionOut;
  logic [31:0]         addressDataOut;
  logic [BURST_W-1:0]  burstSizeOut;
  logic                readNotWriteOut;
  logic                dataValidOut;
  logic                endTransactionOut;
  logic [31:0]         addressDataIn;
  logic                dataValidIn;
  logic                endTransactionIn;
  logic                busyIn;
  logic                busErrorIn;

  modport master (
    output requestTransaction,
    output beginTransactionOut,
    output addressDataOut,
    output burstSizeOut,
    output readNotWriteOut,
    output dataValidOut,
    output endTransactionOut,
    input  transactionGranted,
    input  addressDataIn,
    input  dataValidIn,
    input  endTransactionIn,
    input  busyIn,
    input  busErrorIn
  );

  modport slave (
    input  requestTransaction,
    input  beginTransactionOut,
    input  addressDataOut,
    input  burstSizeOut,
    input  readNotWriteOut,
    input  dataValidOut,
    input  endTransactionOut,
    output transactionGranted,
    output addressDataIn,
    output dataValidIn,
    output endTransactionIn,
    output busyIn,
    output busErrorIn
  );

endinterface

// File: rtl/dma_burst_counter.sv
// Remaining-word and beat bookkeeping, burst length selection and address stepping
// for one DMA block transfer.
module dma_burst_counter #(
  parameter int unsigned MEM_AW  = dma_pkg::MEM_AW,
  parameter int unsigned BLOCK_W = dma_pkg::BLOCK_W,
  parameter int unsigned BURST_W = dma_pkg::BURST_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_i,
  input  logic               burst_init_i,
  input  logic               step_i,
  input  logic [31:0]        bus_addr_i,
  input  logic [MEM_AW-1:0]  mem_addr_i,
  input  logic [BLOCK_W-1:0] block_size_i,
  input  logic [BURST_W-1:0] burst_size_i,
  output logic [31:0]        bus_addr_o,
  output logic [MEM_AW-1:0]  mem_addr_o,
  output logic [MEM_AW-1:0]  mem_addr_inc_o,
  output logic [BURST_W-1:0] burst_size_out_o,
  output logic               room_o,
  output logic               last_beat_o,
  output logic               rem_zero_o,
  output logic               rem_one_o
);
  import dma_pkg::*;

  // Wide enough for both burstSize+1 and the block size
  localparam int unsigned CNT_W = ((BURST_W + 1) > BLOCK_W) ? (BURST_W + 1) : BLOCK_W;

  logic [BLOCK_W-1:0] remaining_q, remaining_d;
  logic [BURST_W-1:0] burst_size_q, burst_size_d;
  logic [CNT_W-1:0]   burst_len_q, burst_len_d;
  logic [CNT_W-1:0]   beat_q, beat_d;
  logic [31:0]        bus_addr_q, bus_addr_d;
  logic [MEM_AW-1:0]  mem_addr_q, mem_addr_d;

  logic [CNT_W-1:0]   burst_cap_c;
  logic [CNT_W-1:0]   rem_ext_c;
  logic [CNT_W-1:0]   burst_len_c;

  assign burst_cap_c = CNT_W'(burst_size_q) + CNT_W'(1);
  assign rem_ext_c   = CNT_W'(remaining_q);
  assign burst_len_c = (burst_cap_c < rem_ext_c) ? burst_cap_c : rem_ext_c;

  // A beat may only count while both the burst and the block still have room
  assign room_o           = (beat_q != burst_len_q) && (remaining_q != '0);
  assign last_beat_o      = ((beat_q + CNT_W'(1)) == burst_len_q);
  assign rem_zero_o       = (remaining_q == '0);
  assign rem_one_o        = (remaining_q == BLOCK_W'(1));
  assign bus_addr_o       = bus_addr_q;
  assign mem_addr_o       = mem_addr_q;
  assign mem_addr_inc_o   = mem_addr_q + MEM_AW'(1);
  assign burst_size_out_o = BURST_W'(burst_len_q - CNT_W'(1));

  always_comb begin
    remaining_d  = remaining_q;
    burst_size_d = burst_size_q;
    burst_len_d  = burst_len_q;
    beat_d       = beat_q;
    bus_addr_d   = bus_addr_q;
    mem_addr_d   = mem_addr_q;
    if (load_i) begin
      remaining_d  = block_size_i;
      burst_size_d = burst_size_i;
      burst_len_d  = '0;
      beat_d       = '0;
      bus_addr_d   = bus_addr_i;
      mem_addr_d   = mem_addr_i;
    end else if (burst_init_i) begin
      burst_len_d = burst_len_c;
      beat_d      = '0;
    end else if (step_i && room_o) begin
      remaining_d = remaining_q - BLOCK_W'(1);
      beat_d      = beat_q + CNT_W'(1);
      bus_addr_d  = bus_addr_q + BUS_WORD_STEP;
      mem_addr_d  = mem_addr_q + MEM_AW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      remaining_q  <= '0;
      burst_size_q <= '0;
      burst_len_q  <= '0;
      beat_q       <= '0;
      bus_addr_q   <= '0;
      mem_addr_q   <= '0;
    end else begin
      remaining_q  <= remaining_d;
      burst_size_q <= burst_size_d;
      burst_len_q  <= burst_len_d;
      beat_q       <= beat_d;
      bus_addr_q   <= bus_addr_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

endmodule

// File: rtl/dma_transfer_controller.sv
// DMA sequencer: splits a block into bus bursts and moves words between the
// system bus and port B of the local DMA memory.
module dma_transfer_controller #(
  parameter int unsigned MEM_AW  = dma_pkg::MEM_AW,
  parameter int unsigned BLOCK_W = dma_pkg::BLOCK_W,
  parameter int unsigned BURST_W = dma_pkg::BURST_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                startTransfer,
  input  logic                readNotWrite,
  input  logic [31:0]         busStartAddress,
  input  logic [MEM_AW-1:0]   memStartAddress,
  input  logic [BLOCK_W-1:0]  blockSize,
  input  logic [BURST_W-1:0]  burstSize,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [MEM_AW-1:0]   memAddress,
  output logic                memWriteEnable,
  output logic [31:0]         memWriteData,
  input  logic [31:0]         memReadData,
  dma_transfer_controller_if.master bus
);
  import dma_pkg::*;

  dma_state_e state_q, state_d;
  logic       dir_q;
  logic       error_q, error_d;

  logic               cnt_load, cnt_burst_init, cnt_step;
  logic [31:0]        cnt_bus_addr;
  logic [MEM_AW-1:0]  cnt_mem_addr, cnt_mem_addr_inc;
  logic [BURST_W-1:0] cnt_burst_size_out;
  logic               cnt_room, cnt_last_beat, cnt_rem_zero, cnt_rem_one;

  logic               req_c, begin_c, rnw_out_c, dvo_c, end_out_c, done_c;
  logic [31:0]        ado_c;
  logic [BURST_W-1:0] bso_c;
  logic [MEM_AW-1:0]  mem_addr_c;
  logic               mem_we_c;
  logic [31:0]        mem_wd_c;

  dma_burst_counter #(
    .MEM_AW (MEM_AW),
    .BLOCK_W(BLOCK_W),
    .BURST_W(BURST_W)
  ) u_counter (
    .clock           (clock),
    .reset           (reset),
    .load_i          (cnt_load),
    .burst_init_i    (cnt_burst_init),
    .step_i          (cnt_step),
    .bus_addr_i      (busStartAddress),
    .mem_addr_i      (memStartAddress),
    .block_size_i    (blockSize),
    .burst_size_i    (burstSize),
    .bus_addr_o      (cnt_bus_addr),
    .mem_addr_o      (cnt_mem_addr),
    .mem_addr_inc_o  (cnt_mem_addr_inc),
    .burst_size_out_o(cnt_burst_size_out),
    .room_o          (cnt_room),
    .last_beat_o     (cnt_last_beat),
    .rem_zero_o      (cnt_rem_zero),
    .rem_one_o       (cnt_rem_one)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
      if (cnt_load) begin
        dir_q <= readNotWrite;
      end
    end
  end

  // Next state, counter control and bus/memory strobes
  always_comb begin
    state_d        = state_q;
    error_d        = error_q;
    cnt_load       = 1'b0;
    cnt_burst_init = 1'b0;
    cnt_step       = 1'b0;
    req_c          = 1'b0;
    begin_c        = 1'b0;
    rnw_out_c      = 1'b0;
    dvo_c          = 1'b0;
    end_out_c      = 1'b0;
    done_c         = 1'b0;
    ado_c          = '0;
    bso_c          = '0;
    mem_addr_c     = '0;
    mem_we_c       = 1'b0;
    mem_wd_c       = '0;

    case (state_q)
      ST_IDLE: begin
        if (startTransfer) begin
          cnt_load = 1'b1;
          error_d  = 1'b0;
          state_d  = (blockSize == '0) ? ST_FINISH : ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        req_c          = 1'b1;
        cnt_burst_init = 1'b1;
        if (bus.transactionGranted) begin
          state_d = ST_BEGIN;
        end
      end
      ST_BEGIN: begin
        begin_c   = 1'b1;
        ado_c     = cnt_bus_addr;
        bso_c     = cnt_burst_size_out;
        rnw_out_c = dir_q;
        // Prime the memory read so the first write beat has its data next cycle
        if (!dir_q) begin
          mem_addr_c = cnt_mem_addr;
        end
        if (bus.busErrorIn) begin
          state_d = ST_ERROR;
        end else begin
          state_d = dir_q ? ST_READ : ST_WRITE;
        end
      end
      ST_READ: begin
        mem_addr_c = cnt_mem_addr;
        if (bus.busErrorIn) begin
          state_d = ST_ERROR;
        end else begin
          if (bus.dataValidIn && cnt_room) begin
            mem_we_c = 1'b1;
            mem_wd_c = bus.addressDataIn;
            cnt_step = 1'b1;
          end
          if (bus.endTransactionIn) begin
            state_d = (cnt_step ? cnt_rem_one : cnt_rem_zero) ? ST_FINISH : ST_REQUEST;
          end
        end
      end
      ST_WRITE: begin
        dvo_c      = 1'b1;
        ado_c      = memReadData;
        mem_addr_c = cnt_mem_addr;
        if (bus.busErrorIn) begin
          state_d = ST_ERROR;
        end else if (!bus.busyIn) begin
          // Fetch ahead only on accept so a stalled beat keeps its data
          cnt_step   = 1'b1;
          mem_addr_c = cnt_mem_addr_inc;
          if (cnt_last_beat) begin
            state_d = ST_END_WRITE;
          end
        end
      end
      ST_END_WRITE: begin
        end_out_c = 1'b1;
        if (bus.busErrorIn) begin
          state_d = ST_ERROR;
        end else begin
          state_d = cnt_rem_zero ? ST_FINISH : ST_REQUEST;
        end
      end
      ST_FINISH: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERROR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_ERROR) begin
      error_d = 1'b1;
    end
  end

  assign busy  = (state_q == ST_REQUEST) || (state_q == ST_BEGIN) || (state_q == ST_READ) ||
                 (state_q == ST_WRITE) || (state_q == ST_END_WRITE);
  assign done  = done_c;
  assign error = error_q;

  assign memAddress     = mem_addr_c;
  assign memWriteEnable = mem_we_c;
  assign memWriteData   = mem_wd_c;

  assign bus.requestTransaction  = req_c;
  assign bus.beginTransactionOut = begin_c;
  assign bus.addressDataOut      = ado_c;
  assign bus.burstSizeOut        = bso_c;
  assign bus.readNotWriteOut     = rnw_out_c;
  assign bus.dataValidOut        = dvo_c;
  assign bus.endTransactionOut   = end_out_c;

endmodule

// File: doc/dma_transfer_controller.md
Name: dma_transfer_controller

Overview:
Sequences the DMA datapath that moves a block of 32-bit words between the shared system bus and the 512-word local DMA memory. The custom-instruction register file supplies the configuration and the start pulse. This block sits between that register file, port B of the DMA memory, and the bus arbiter/bus.
- Requests the bus and splits the block into bursts.
- Drives the bus handshake.
- Reports busy, done and error.

Parameters:
MEM_AW, 9, local memory address width (words)
BLOCK_W, 10, block size width (words)
BURST_W, 8, bus burst size field width (encoded as beats-1)

Ports:
clock  in  1  single system clock
reset  in  1  synchronous, active-high reset
startTransfer  in  1  one-cycle start pulse from CI control register
readNotWrite  in  1  1: bus->memory, 0: memory->bus; sampled at start
busStartAddress  in  32  word-aligned bus byte address; sampled at start
memStartAddress  in  MEM_AW  local word address; sampled at start
blockSize  in  BLOCK_W  words to move; sampled at start
burstSize  in  BURST_W  max beats per burst minus 1; sampled at start
busy  out  1  transfer in progress
done  out  1  one-cycle pulse on successful completion
error  out  1  sticky bus-error flag, cleared by next accepted start
memAddress  out  MEM_AW  DMA memory port B address
memWriteEnable  out  1  port B write strobe
memWriteData  out  32  port B write data
memReadData  in  32  port B read data, 1-cycle registered latency
requestTransaction  out  1  bus request to arbiter
transactionGranted  in  1  arbiter grant
beginTransactionOut  out  1  one-cycle burst start
addressDataOut  out  32  address in begin cycle, write data in data beats, else 0
burstSizeOut  out  BURST_W  beats-1 of current burst, valid with begin, else 0
readNotWriteOut  out  1  direction, valid with begin, else 0
dataValidOut  out  1  write beat valid
endTransactionOut  out  1  one-cycle end after last write beat
addressDataIn  in  32  read data
dataValidIn  in  1  read beat valid
endTransactionIn  in  1  slave ends read burst
busyIn  in  1  slave stall; write beat not accepted while 1
busErrorIn  in  1  bus error

Behaviour:
- Reset, whether idle or mid-transfer: state IDLE. Every output is 0 on the cycle after reset is high. Configuration latches and counters are 0.
- States: IDLE, REQUEST, BEGIN, READ, WRITE, END_WRITE, FINISH, ERROR.
- IDLE, on startTransfer:
  - Latch config; set remaining = blockSize; clear error.
  - blockSize==0 -> FINISH.
  - Otherwise -> REQUEST; busy=1 from the next cycle.
  - startTransfer while busy is ignored.
- REQUEST:
  - requestTransaction=1 until BEGIN.
  - burstLen = min(burstSize+1, remaining).
  - transactionGranted -> BEGIN.
- BEGIN (exactly 1 cycle):
  - beginTransactionOut=1, addressDataOut=current bus address, burstSizeOut=burstLen-1, readNotWriteOut=direction.
  - In write mode, memAddress = current mem address, so the first word is available next cycle.
  - Next state is READ or WRITE.
- READ:
  - Each cycle with dataValidIn=1: memWriteEnable=1, memWriteData=addressDataIn, memAddress=current; then mem address +1, bus address +4, remaining -1.
  - endTransactionIn=1 (same-cycle beat still written): remaining==0 -> FINISH, else -> REQUEST.
  - A short burst is not an error; the next burst recomputes burstLen.
- WRITE:
  - dataValidOut=1, addressDataOut=memReadData.
  - Beat accepted when busyIn=0. On accept: mem address +1, bus address +4, remaining -1, beat counter +1.
  - memAddress = accept ? current+1 : current, so memReadData always holds the present beat under stall.
  - Last beat of the burst accepted -> END_WRITE.
- END_WRITE (1 cycle):
  - endTransactionOut=1, dataValidOut=0.
  - remaining==0 -> FINISH, else -> REQUEST.
- FINISH: done=1 for one cycle, busy=0, -> IDLE.
- busErrorIn in BEGIN, READ, WRITE or END_WRITE -> ERROR.
  - ERROR: all bus outputs 0, error=1 (sticky), busy=0, no done; -> IDLE next cycle.
  - Words already moved stay moved.
- Arithmetic:
  - Memory address wraps modulo 2^MEM_AW (511 -> 0).
  - Bus address wraps modulo 2^32.
  - remaining never underflows; beats beyond burstLen are ignored.
- When a read beat and endTransactionIn arrive together, the beat is written before the state change.

Decomposition:
- Shared package dma_pkg:
  - state enum localparams;
  - bus field widths (BURST_W = 8, data 32);
  - DMA memory depth constant (512).
- One natural sub-module, dma_burst_counter: holds remaining, beat count and burstLen computation, plus address increment and wrap. The FSM instantiates it.

Test Plan:
- Read, blockSize=4, burstSize=15, bus 0x1000, mem 0 -> one burst with burstSizeOut=3; mem[0..3] = slave data; done 1 cycle after endTransactionIn.
- Read, blockSize=20, burstSize=7 -> three bursts:
  - burstSizeOut 7,7,3;
  - begin addresses 0x1000, 0x1020, 0x1040;
  - requestTransaction drops between bursts.
- Write, blockSize=3, mem 510, busyIn=1 for 2 cycles on beat 2:
  - beats = mem[510], mem[511], mem[0];
  - beat 2 held stable while stalled;
  - endTransactionOut 1 cycle after the last accept.
- busErrorIn on read beat 2 of 8 -> ERROR; error=1, busy=0, no done. The next start clears error and completes normally.
- reset asserted mid-WRITE -> all outputs 0 next cycle, IDLE; startTransfer while busy has no effect.
- blockSize=0 start -> done 1 cycle later, requestTransaction never asserted.
